// File: rtl/bus_arbiter_4.sv
// Round-robin arbiter/sequencer sharing one downstream bus port among four requesters,
// with valid/ready handshake, per-requester ack/err pulses and a stall timeout.
module bus_arbiter_4 #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       bus_ready,
    output logic [1:0] sel,
    output logic [3:0] grant,
    output logic       bus_valid,
    output logic [3:0] ack,
    output logic [3:0] err,
    output logic       busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter value seen during the last BUSY cycle allowed before abort.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t          state;
    logic [1:0]      ptr;
    logic [TO_W-1:0] count;
    logic [1:0]      winner;

    // First asserted request in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = p;
        for (int k = 3; k >= 0; k--) begin
            idx = p + 2'(k);
            if (r[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

    always_comb begin
        winner = rr_pick(req, ptr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            ptr       <= 2'd0;
            count     <= '0;
            sel       <= 2'd0;
            grant     <= 4'd0;
            bus_valid <= 1'b0;
            ack       <= 4'd0;
            err       <= 4'd0;
            busy      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack <= 4'd0;
                    err <= 4'd0;
                    if (|req) begin
                        sel       <= winner;
                        grant     <= 4'b0001 << winner;
                        bus_valid <= 1'b1;
                        busy      <= 1'b1;
                        count     <= '0;
                        state     <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // bus_ready wins over an expiring timeout in the same cycle.
                    if (bus_ready) begin
                        ack       <= grant;
                        bus_valid <= 1'b0;
                        ptr       <= sel + 2'd1;
                        state     <= ST_DONE;
                    end else if ((TIMEOUT != 0) && (count == TO_LAST)) begin
                        err       <= grant;
                        bus_valid <= 1'b0;
                        ptr       <= sel + 2'd1;
                        state     <= ST_DONE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                ST_DONE: begin
                    ack   <= 4'd0;
                    err   <= 4'd0;
                    grant <= 4'd0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_arbiter_4.sv
// Bench for bus_arbiter_4: vector table on a default instance, hand-written corner
// sequences, and randomized traffic on a TIMEOUT=4 instance against a transaction model.
module tb_bus_arbiter_4;

    localparam int TO_B = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req_a, req_b;
    logic       rdy_a, rdy_b;
    logic [1:0] sel_a, sel_b;
    logic [3:0] grant_a, grant_b, ack_a, ack_b, err_a, err_b;
    logic       valid_a, valid_b, busy_a, busy_b;
    logic [15:0] obs_a, obs_b;

    int n_cmp;
    int n_fail;

    bus_arbiter_4 u_dut (
        .clk(clk), .rst(rst), .req(req_a), .bus_ready(rdy_a),
        .sel(sel_a), .grant(grant_a), .bus_valid(valid_a),
        .ack(ack_a), .err(err_a), .busy(busy_a)
    );

    bus_arbiter_4 #(.TIMEOUT(TO_B), .TO_W(3)) u_to (
        .clk(clk), .rst(rst), .req(req_b), .bus_ready(rdy_b),
        .sel(sel_b), .grant(grant_b), .bus_valid(valid_b),
        .ack(ack_b), .err(err_b), .busy(busy_b)
    );

    assign obs_a = {sel_a, grant_a, valid_a, ack_a, err_a, busy_a};
    assign obs_b = {sel_b, grant_b, valid_b, ack_b, err_b, busy_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic        rdy;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [15:0] pk(input logic [1:0] s, input logic [3:0] g, input logic v,
                                       input logic [3:0] a, input logic [3:0] e, input logic b);
        return {s, g, v, a, e, b};
    endfunction

    task automatic add(input logic r, input logic [3:0] q, input logic rd, input logic [1:0] s,
                       input logic [3:0] g, input logic v, input logic [3:0] a,
                       input logic [3:0] e, input logic b);
        vec_t t;
        t.rst = r;
        t.req = q;
        t.rdy = rd;
        t.exp = pk(s, g, v, a, e, b);
        tbl.push_back(t);
    endtask

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got sel=%0d grant=%b valid=%b ack=%b err=%b busy=%b, want sel=%0d grant=%b valid=%b ack=%b err=%b busy=%b",
                     name, act[15:14], act[13:10], act[9], act[8:5], act[4:1], act[0],
                     exp[15:14], exp[13:10], exp[9], exp[8:5], exp[4:1], exp[0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference for the TIMEOUT=4 instance.
    int          m_owner;
    int          m_waited;
    int          m_ptr;
    bit          m_done;
    logic [15:0] m_obs;

    task automatic model_reset();
        m_owner  = -1;
        m_waited = 0;
        m_ptr    = 0;
        m_done   = 1'b0;
        m_obs    = 16'd0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic rd);
        logic [1:0] s;
        logic [3:0] g, a, e;
        logic       v, b;
        int         w;
        {s, g, v, a, e, b} = m_obs;
        a = 4'd0;
        e = 4'd0;
        if (m_done) begin
            m_done  = 1'b0;
            m_owner = -1;
            g = 4'd0;
            b = 1'b0;
        end else if (m_owner < 0) begin
            w = -1;
            for (int i = 0; i < 4; i++) begin
                if (w < 0 && r[(m_ptr + i) % 4]) w = (m_ptr + i) % 4;
            end
            if (w >= 0) begin
                m_owner  = w;
                m_waited = 0;
                s = 2'(w);
                g = 4'(1 << w);
                v = 1'b1;
                b = 1'b1;
            end
        end else begin
            m_waited++;
            if (rd) a = g;
            else if (m_waited == TO_B) e = g;
            if (rd || m_waited == TO_B) begin
                v      = 1'b0;
                m_done = 1'b1;
                m_ptr  = (m_owner + 1) % 4;
            end
        end
        m_obs = {s, g, v, a, e, b};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] pend;
        n_cmp  = 0;
        n_fail = 0;
        rst    = 1'b1;
        req_a  = 4'd0;
        req_b  = 4'd0;
        rdy_a  = 1'b0;
        rdy_b  = 1'b0;

        // Single request for requester 2, then ptr=3 picks 3 over 0, then 0 wraps.
        add(0, 4'b0100, 1, 2'd2, 4'b0100, 1, 4'b0000, 4'b0000, 1);
        add(0, 4'b0100, 1, 2'd2, 4'b0100, 0, 4'b0100, 4'b0000, 1);
        add(0, 4'b0000, 1, 2'd2, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        add(0, 4'b1001, 1, 2'd3, 4'b1000, 1, 4'b0000, 4'b0000, 1);
        add(0, 4'b1001, 1, 2'd3, 4'b1000, 0, 4'b1000, 4'b0000, 1);
        add(0, 4'b0001, 1, 2'd3, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        add(0, 4'b0001, 1, 2'd0, 4'b0001, 1, 4'b0000, 4'b0000, 1);
        add(0, 4'b0001, 1, 2'd0, 4'b0001, 0, 4'b0001, 4'b0000, 1);
        add(0, 4'b0000, 1, 2'd0, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        // Reset, then all four requesting with a zero-wait slave: 0,1,2,3,0.
        add(1, 4'b0000, 1, 2'd0, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        for (int k = 0; k < 5; k++) begin
            add(0, 4'b1111, 1, 2'(k % 4), 4'(1 << (k % 4)), 1, 4'b0000, 4'b0000, 1);
            add(0, 4'b1111, 1, 2'(k % 4), 4'(1 << (k % 4)), 0, 4'(1 << (k % 4)), 4'b0000, 1);
            add(0, (k == 4) ? 4'b0000 : 4'b1111, 1, 2'(k % 4), 4'b0000, 0, 4'b0000, 4'b0000, 0);
        end
        // Owner 1 with five wait states: six cycles of bus_valid, then ack.
        for (int k = 0; k < 6; k++) begin
            add(0, 4'b0010, 0, 2'd1, 4'b0010, 1, 4'b0000, 4'b0000, 1);
        end
        add(0, 4'b0010, 1, 2'd1, 4'b0010, 0, 4'b0010, 4'b0000, 1);
        add(0, 4'b0000, 0, 2'd1, 4'b0000, 0, 4'b0000, 4'b0000, 0);
        // Requester 2 withdraws during BUSY and still completes.
        add(0, 4'b0100, 0, 2'd2, 4'b0100, 1, 4'b0000, 4'b0000, 1);
        add(0, 4'b0000, 0, 2'd2, 4'b0100, 1, 4'b0000, 4'b0000, 1);
        add(0, 4'b0000, 1, 2'd2, 4'b0100, 0, 4'b0100, 4'b0000, 1);
        add(0, 4'b0000, 0, 2'd2, 4'b0000, 0, 4'b0000, 4'b0000, 0);

        #2;
        check("reset_state", obs_a, 16'd0);
        tick();
        rst = 1'b0;

        foreach (tbl[i]) begin
            rst   = tbl[i].rst;
            req_a = tbl[i].req;
            rdy_a = tbl[i].rdy;
            tick();
            check($sformatf("vec%0d", i), obs_a, tbl[i].exp);
        end
        rst = 1'b0;

        // Asynchronous reset mid-BUSY; ptr is 3 here, so 3 wins before reset and 0 after.
        req_a = 4'b1001;
        rdy_a = 1'b0;
        tick();
        check("pre_rst_busy", obs_a, pk(2'd3, 4'b1000, 1, 4'd0, 4'd0, 1));
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_now", obs_a, 16'd0);
        tick();
        check("async_rst_held", obs_a, 16'd0);
        rst = 1'b0;
        tick();
        check("post_rst_ptr0", obs_a, pk(2'd0, 4'b0001, 1, 4'd0, 4'd0, 1));
        req_a = 4'b0001;
        rdy_a = 1'b1;
        tick();
        check("post_rst_ack", obs_a, pk(2'd0, 4'b0001, 0, 4'b0001, 4'd0, 1));
        req_a = 4'b0000;
        rdy_a = 1'b0;
        tick();
        check("post_rst_idle", obs_a, pk(2'd0, 4'd0, 0, 4'd0, 4'd0, 0));

        // Timeout abort after four stalled BUSY cycles, then the next requester is served.
        req_b = 4'b0011;
        rdy_b = 1'b0;
        tick();
        check("to_grant0", obs_b, pk(2'd0, 4'b0001, 1, 4'd0, 4'd0, 1));
        for (int k = 0; k < 3; k++) begin
            tick();
            check("to_wait", obs_b, pk(2'd0, 4'b0001, 1, 4'd0, 4'd0, 1));
        end
        tick();
        check("to_err", obs_b, pk(2'd0, 4'b0001, 0, 4'd0, 4'b0001, 1));
        req_b = 4'b0010;
        tick();
        check("to_idle", obs_b, pk(2'd0, 4'd0, 0, 4'd0, 4'd0, 0));
        tick();
        check("to_next_owner", obs_b, pk(2'd1, 4'b0010, 1, 4'd0, 4'd0, 1));
        for (int k = 0; k < 3; k++) begin
            tick();
            check("to_wait2", obs_b, pk(2'd1, 4'b0010, 1, 4'd0, 4'd0, 1));
        end
        rdy_b = 1'b1;
        tick();
        check("to_late_ack", obs_b, pk(2'd1, 4'b0010, 0, 4'b0010, 4'd0, 1));
        req_b = 4'b0000;
        rdy_b = 1'b0;
        tick();
        check("to_late_idle", obs_b, pk(2'd1, 4'd0, 0, 4'd0, 4'd0, 0));

        // Randomized traffic on the TIMEOUT=4 instance.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        pend = 4'd0;
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) pend = pend | 4'($urandom_range(0, 15));
            req_b = pend;
            rdy_b = ($urandom_range(0, 3) == 0);
            model_edge(req_b, rdy_b);
            tick();
            check($sformatf("rand%0d", c), obs_b, m_obs);
            pend = pend & ~(m_obs[8:5] | m_obs[4:1]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_arbiter_4.md
# bus_arbiter_4

Round-robin arbiter and sequencer that shares one downstream bus port between four requesters. It drives the 2-bit select of the 4-way 32-bit datapath multiplexer that routes the winning requester's address/data onto the shared port. It runs each transaction through a valid/ready handshake with the downstream slave, returns a per-requester completion or error pulse, and aborts transactions that stall past a programmable timeout.

## Interface
Parameters:
- TIMEOUT, default 255: number of BUSY cycles allowed without bus_ready before abort; 0 disables the timeout.
- TO_W, default 8: width of the timeout counter; must satisfy TIMEOUT < 2^TO_W.

Ports (one clock; reset is asynchronous and active-high):
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  4  per-requester request, level; bit i held high until ack[i] or err[i].
- bus_ready  input  1  downstream slave accepts/completes the current transfer.
- sel  output  2  mux select, index of the current or last owner; drives the shared-port multiplexer.
- grant  output  4  one-hot owner indication, high through BUSY and DONE.
- bus_valid  output  1  transfer on the shared port is valid.
- ack  output  4  one-cycle completion pulse to the owner.
- err  output  4  one-cycle timeout-abort pulse to the owner.
- busy  output  1  arbiter is not in IDLE.

## Operation
- All outputs are registered. Reset values: sel=0, grant=0, bus_valid=0, ack=0, err=0, busy=0, state=IDLE, ptr=0, counter=0.
- Round-robin pointer ptr[1:0]: search order is ptr, ptr+1, ptr+2, ptr+3 (mod 4). The first asserted req wins. After the DONE state for owner i, ptr is set to (i+1) mod 4.
- State IDLE: if req is 0, stay in IDLE. Otherwise latch winner w. At the next edge: sel=w, grant=1<<w, bus_valid=1, busy=1, counter=0, go to BUSY.
- State BUSY: bus_valid=1; sel and grant are held constant. req changes are ignored, and a withdrawn request still completes.
  - bus_ready=1: go to DONE with ack[w]=1.
  - else if TIMEOUT≠0 and counter==TIMEOUT-1: go to DONE with err[w]=1.
  - else counter+=1 and stay in BUSY.
  - bus_ready high in the timeout cycle counts as success: ack is raised, err is not.
- State DONE (exactly one cycle): bus_valid=0; ack or err is high for this cycle only; grant and sel are held; ptr is updated. Next state is IDLE, with grant=0 and busy=0.
- sel keeps its last value in IDLE; it is not cleared after a transaction.
- ack and err are never high together and are never high for a non-owner.
- rst asserted in any state, including mid-transaction, immediately forces the reset values. No ack or err is issued for the aborted transfer.

## Timing
- Arbitration latency: req sampled high in IDLE at edge N gives bus_valid/grant/sel valid after edge N+1.
- Zero-wait slave (bus_ready high in the first BUSY cycle) gives ack in the second cycle after grant. Total cost is 3 cycles per transaction: IDLE, BUSY, DONE.
- Back-to-back: a requester keeping req high competes again in IDLE, but ptr has already advanced past it.
- Timeout abort: err appears in the cycle after the TIMEOUT-th BUSY cycle without bus_ready.
- bus_valid is never high in IDLE or DONE. Consecutive transactions are always separated by one cycle of bus_valid low.

## Test plan
- Reset then single request: req=4'b0100, bus_ready tied 1. Required: sel=2, grant=4'b0100, bus_valid for 1 cycle, ack=4'b0100 for 1 cycle, then ptr=3.
- All requesting, bus_ready=1, starting from ptr=0. Required: grants in order 0,1,2,3,0, each with one ack pulse and 3 cycles per grant.
- Wait states: owner 1, bus_ready low for 5 BUSY cycles then high. Required: bus_valid high for 6 cycles with sel=1 held, then ack[1], err=0.
- Timeout with TIMEOUT=4, bus_ready stuck 0. Required: err[owner] after 4 BUSY cycles, no ack, ptr advanced, next requester served. Variant with bus_ready high exactly in the 4th cycle: ack, not err.
- Request withdrawal: req[2] dropped during BUSY. Required: transaction still completes with ack[2].
- Async reset asserted mid-BUSY, between clock edges. Required: all outputs 0 immediately, no ack or err. After release, arbitration restarts from ptr=0.
